// File: rtl/fetch_sequencer_if.sv
// Instruction-ROM address/data bus and datapath issue handshake of the
// fetch sequencer. The master side is the sequencer; the slave side is the
// ROM plus datapath.
interface fetch_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    rom_pc;
  logic [INSTR_W-1:0] rom_instr;
  logic               issue_valid;
  logic [INSTR_W-1:0] issue_instr;
  logic               issue_ready;

  modport master (
    output rom_pc,
    input  rom_instr,
    output issue_valid,
    output issue_instr,
    input  issue_ready
  );

  modport slave (
    input  rom_pc,
    output rom_instr,
    input  issue_valid,
    input  issue_instr,
    output issue_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program sequencer for the washing register machine. It owns the program
// counter, fetches and latches instructions from a combinational ROM, resolves
// HALT/JMP/BRF/WAIT itself and hands every other opcode to the datapath over
// a valid/ready issue handshake.
module fetch_sequencer #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0,
  parameter int WAIT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               cond_flag,
  output logic               busy,
  output logic               halted,
  fetch_sequencer_if.master  bus
);

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  // Control-flow opcodes resolved locally; everything else goes to the datapath.
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_BRF  = 4'hD;
  localparam logic [3:0] OP_WAIT = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]         opcode;
  logic [7:0]         operand;
  logic [PC_W-1:0]    pc_inc;

  assign opcode  = ir_q[15:12];
  assign operand = ir_q[7:0];
  assign pc_inc  = pc_q + PC_W'(1);

  // State, pc, instruction and wait-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: sequencing per state, abort overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        ir_d    = bus.rom_instr;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        unique case (opcode)
          OP_HALT: state_d = S_HALT;
          OP_JMP: begin
            pc_d    = PC_W'(operand);
            state_d = S_FETCH;
          end
          OP_BRF: begin
            pc_d    = cond_flag ? PC_W'(operand) : pc_inc;
            state_d = S_FETCH;
          end
          OP_WAIT: begin
            if (operand == 8'd0) begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end else begin
              cnt_d   = WAIT_W'(operand);
              state_d = S_WAIT;
            end
          end
          default: state_d = S_ISSUE;
        endcase
      end

      S_ISSUE: begin
        if (bus.issue_ready) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end

      S_WAIT: begin
        // Counter holds cycles remaining including this one, so leaving on
        // cnt==1 gives exactly n cycles in WAIT.
        if (cnt_q == WAIT_W'(1)) begin
          cnt_d   = '0;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end

      S_HALT: begin
        if (start) begin
          pc_d    = PC_RST;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      pc_d    = PC_RST;
      cnt_d   = '0;
    end
  end

  // Outputs decoded purely from registers; issue_instr reads zero when idle.
  assign bus.rom_pc      = pc_q;
  assign bus.issue_valid = (state_q == S_ISSUE);
  assign bus.issue_instr = (state_q == S_ISSUE) ? ir_q : '0;
  assign busy            = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                           (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign halted          = (state_q == S_HALT);

endmodule
